// File: rtl/weight_pkg.sv
`default_nettype none
// weight_pkg: shared FSM state encoding and lane layout for the weight fetch controller.
package weight_pkg;

  localparam int LANES          = 4;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = BYTES_PER_WORD * 8;
  localparam int WORD_W         = LANES * LANE_W;

  localparam int LANE_A_LSB = 0 * LANE_W;
  localparam int LANE_B_LSB = 1 * LANE_W;
  localparam int LANE_C_LSB = 2 * LANE_W;
  localparam int LANE_D_LSB = 3 * LANE_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic logic [LANE_W-1:0] lane_word(input logic [WORD_W-1:0] w, input int lsb);
    return w[lsb +: LANE_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/weight_fetch_ctrl.sv
`default_nettype none
// weight_fetch_ctrl: reads one 128-bit SRAM word per tile and drives the 4-lane feeder load/shift handshake.
// Optional WEIGHT_FETCH_PERF_EN adds a saturating stall_cnt output counting stalled SHIFT cycles.
module weight_fetch_ctrl
  import weight_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        num_tiles,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              wf_en_in,
  output logic              wf_en_out,
  output logic [LANE_W-1:0] wf_dinA,
  output logic [LANE_W-1:0] wf_dinB,
  output logic [LANE_W-1:0] wf_dinC,
`ifdef WEIGHT_FETCH_PERF_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [LANE_W-1:0] wf_dinD
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [7:0]        r_num_tiles;
  logic [7:0]        r_tile_idx;
  logic [1:0]        r_shift_cnt;
  logic [1:0]        r_lat_cnt;
  logic [7:0]        w_tile_inc;
  logic              w_start_acc;
  logic              w_last_shift;
  logic              w_last_tile;
  logic              w_lat_done;
  logic [ADDR_W-1:0] w_rd_addr;

  assign wf_en_out    = (r_state == ST_SHIFT) && !stall;
  assign w_start_acc  = (r_state == ST_IDLE) && start;
  assign w_tile_inc   = r_tile_idx + 8'd1;
  assign w_last_tile  = (w_tile_inc == r_num_tiles);
  assign w_last_shift = wf_en_out && (r_shift_cnt == 2'd3);
  assign w_lat_done   = (r_lat_cnt == 2'(MEM_LAT - 1));
  // From IDLE the first read uses the live base; later reads use the next tile index.
  assign w_rd_addr    = (r_state == ST_IDLE) ? base_addr : r_base + ADDR_W'(w_tile_inc);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = (num_tiles != 8'd0) ? ST_READ : ST_DONE;
      ST_READ:  w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_lat_done) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last_shift) w_state_nxt = w_last_tile ? ST_DONE : ST_READ;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      wf_en_in    <= 1'b0;
      wf_dinA     <= '0;
      wf_dinB     <= '0;
      wf_dinC     <= '0;
      wf_dinD     <= '0;
      r_base      <= '0;
      r_num_tiles <= '0;
      r_tile_idx  <= '0;
      r_shift_cnt <= '0;
      r_lat_cnt   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      busy      <= (w_state_nxt != ST_IDLE);
      done      <= (w_state_nxt == ST_DONE);
      mem_rd_en <= (w_state_nxt == ST_READ);
      wf_en_in  <= (w_state_nxt == ST_LOAD);
      if (w_state_nxt == ST_READ) mem_addr <= w_rd_addr;

      if (w_start_acc) begin
        r_base      <= base_addr;
        r_num_tiles <= num_tiles;
        r_tile_idx  <= '0;
        r_shift_cnt <= '0;
      end else begin
        if (w_last_shift && !w_last_tile) r_tile_idx <= w_tile_inc;
        if (wf_en_out) r_shift_cnt <= r_shift_cnt + 2'd1;
      end

      if (r_state == ST_READ)      r_lat_cnt <= '0;
      else if (r_state == ST_WAIT) r_lat_cnt <= r_lat_cnt + 2'd1;

      if ((r_state == ST_WAIT) && w_lat_done) begin
        wf_dinA <= lane_word(mem_rdata, LANE_A_LSB);
        wf_dinB <= lane_word(mem_rdata, LANE_B_LSB);
        wf_dinC <= lane_word(mem_rdata, LANE_C_LSB);
        wf_dinD <= lane_word(mem_rdata, LANE_D_LSB);
      end
    end
  end

`ifdef WEIGHT_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cnt <= '0;
    else if (w_start_acc)
      stall_cnt <= '0;
    else if ((r_state == ST_SHIFT) && stall && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// tb_weight_fetch_ctrl: scoreboard bench driving MEM_LAT=1 and MEM_LAT=3 instances with shared stimulus.
module tb_weight_fetch_ctrl;
  localparam int AW = 10;
  localparam int LAT [2] = '{1, 3};

  typedef struct {
    int           kind;   // 0 read, 1 load, 2 shift, 3 done
    int           cyc;
    logic [127:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [7:0]    num_tiles = '0;

  logic          busy [2], done [2], rd [2], en_in [2], en_out [2];
  logic [AW-1:0] addr [2];
  logic [31:0]   dA [2], dB [2], dC [2], dD [2];
  logic [127:0]  p1;
  logic [127:0]  p3 [3];
`ifdef WEIGHT_FETCH_PERF_EN
  logic [15:0]   scnt [2];
`endif

  ev_t q [2][$];
  int  exp_done [2];
  bit  active = 1'b0;
  int  cyc = 0;
  int  t0 = 0;
  int  n_vec = 0;
  int  n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  weight_fetch_ctrl #(.ADDR_W(AW), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .num_tiles(num_tiles),
    .stall(stall), .busy(busy[0]), .done(done[0]), .mem_rd_en(rd[0]), .mem_addr(addr[0]),
    .mem_rdata(p1), .wf_en_in(en_in[0]), .wf_en_out(en_out[0]),
    .wf_dinA(dA[0]), .wf_dinB(dB[0]), .wf_dinC(dC[0]),
`ifdef WEIGHT_FETCH_PERF_EN
    .stall_cnt(scnt[0]),
`endif
    .wf_dinD(dD[0]));

  weight_fetch_ctrl #(.ADDR_W(AW), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .num_tiles(num_tiles),
    .stall(stall), .busy(busy[1]), .done(done[1]), .mem_rd_en(rd[1]), .mem_addr(addr[1]),
    .mem_rdata(p3[2]), .wf_en_in(en_in[1]), .wf_en_out(en_out[1]),
    .wf_dinA(dA[1]), .wf_dinB(dB[1]), .wf_dinC(dC[1]),
`ifdef WEIGHT_FETCH_PERF_EN
    .stall_cnt(scnt[1]),
`endif
    .wf_dinD(dD[1]));

  // SRAM contents: byte j of lane k at 0x010 is {k,j}; other addresses perturb the pattern.
  function automatic logic [127:0] word(input logic [AW-1:0] a);
    logic [127:0] w;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        w[k*32 + j*8 +: 8] = 8'(k*16 + j) ^ a[7:0] ^ 8'h10 ^ {6'd0, a[9:8]};
    return w;
  endfunction

  // Read data is only valid in its one cycle; otherwise the bus carries garbage.
  always @(posedge clk) begin
    p1    <= rd[0] ? word(addr[0]) : {4{32'hDEADBEEF}};
    p3[0] <= rd[1] ? word(addr[1]) : {4{32'hDEADBEEF}};
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input int k, input int c, input logic [127:0] d, input int cut);
    ev_t e;
    e.kind = k; e.cyc = c; e.data = d;
    if (cut == 0 || c < cut) q[i].push_back(e);
  endtask

  // Expected event stream for one job: tile period 6+L plus any stalled shift cycles.
  task automatic gen(input int i, input logic [AW-1:0] base, input int n,
                     input int slo, input int shi, input int cut);
    int c;
    int s;
    logic [AW-1:0] a;
    c = 1;
    for (int t = 0; t < n; t++) begin
      a = base + AW'(t);
      push(i, 0, c, {118'd0, a}, cut);
      push(i, 1, c + 1 + LAT[i], word(a), cut);
      s = c + 2 + LAT[i];
      for (int k = 0; k < 4; k++) begin
        while (s >= slo && s <= shi) s++;
        push(i, 2, s, '0, cut);
        s++;
      end
      c = s;
    end
    push(i, 3, c, '0, cut);
    exp_done[i] = c;
  endtask

  task automatic take(input int i, input int k, input int rel, input logic [127:0] d, input string nm);
    ev_t e;
    string tag;
    tag = $sformatf("L%0d_%s", LAT[i], nm);
    if (q[i].size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_unexpected: got event at cycle %0d expected none", tag, rel);
    end else begin
      e = q[i].pop_front();
      chk({tag, "_kind"}, 128'(k), 128'(e.kind));
      chk({tag, "_cycle"}, 128'(rel), 128'(e.cyc));
      chk({tag, "_data"}, d, e.data);
    end
  endtask

  task automatic observe(input int i, input int rel);
    if (en_in[i] && en_out[i]) chk($sformatf("L%0d_en_exclusive", LAT[i]), 128'(1), 128'(0));
    if (rd[i])     take(i, 0, rel, {118'd0, addr[i]}, "rd");
    if (en_in[i])  take(i, 1, rel, {dD[i], dC[i], dB[i], dA[i]}, "load");
    if (en_out[i]) take(i, 2, rel, '0, "shift");
    if (done[i])   take(i, 3, rel, '0, "done");
    if (active)
      chk($sformatf("L%0d_busy_c%0d", LAT[i], rel), 128'(busy[i]),
          128'(rel >= 1 && rel <= exp_done[i]));
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      observe(0, cyc - t0);
      observe(1, cyc - t0);
    end
  end

  task automatic chk_idle(input string nm);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_L%0d_ctrl", nm, LAT[i]),
          128'({busy[i], done[i], rd[i], en_in[i], en_out[i]}), 128'(0));
      chk($sformatf("%s_L%0d_addr_din", nm, LAT[i]),
          {8'd0, addr[i], dD[i][29:0], dC[i], dB[i], dA[i]}, '0);
    end
  endtask

  task automatic run(input logic [AW-1:0] base, input int n, input int slo, input int shi,
                     input int spur, input int cut, input bit gen0);
    int endc;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1;
    base_addr = base;
    num_tiles = 8'(n);
    if (gen0) gen(0, base, n, slo, shi, cut);
    gen(1, base, n, slo, shi, cut);
    active = 1'b1;
    endc = (cut != 0) ? cut : ((exp_done[0] > exp_done[1]) ? exp_done[0] : exp_done[1]) + 2;
    for (int r = 1; r <= endc; r++) begin
      @(posedge clk); #1;
      start = (r == spur);
      if (r == spur) begin
        base_addr = ~base;
        num_tiles = 8'd5;
      end
      stall = (r >= slo && r <= shi);
      if (r == cut) begin
        rstn = 1'b0;
        #1;
        chk_idle("async_reset");
      end
    end
    start = 1'b0;
    stall = 1'b0;
    active = 1'b0;
    if (cut != 0) begin
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
    end
    for (int i = 0; i < 2; i++)
      chk($sformatf("L%0d_queue_drained", LAT[i]), 128'(q[i].size()), 128'(0));
  endtask

  initial begin
    #2 chk_idle("reset_state");
    @(posedge clk); #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Single tile, MEM_LAT=1 events written out by hand.
    push(0, 0, 1, 128'h010, 0);
    push(0, 1, 3, {32'h33323130, 32'h23222120, 32'h13121110, 32'h03020100}, 0);
    for (int c = 4; c <= 7; c++) push(0, 2, c, '0, 0);
    push(0, 3, 8, '0, 0);
    exp_done[0] = 8;
    run(10'h010, 1, 0, -1, 0, 0, 1'b0);

    // Address wrap across the top of memory, with a start pulse ignored mid-job.
    run(10'h3FE, 3, 0, -1, 3, 0, 1'b1);

    // Stall during shifting of the only tile.
    run(10'h020, 1, 5, 6, 0, 0, 1'b1);
`ifdef WEIGHT_FETCH_PERF_EN
    chk("L1_stall_cnt", 128'(scnt[0]), 128'(2));
    chk("L3_stall_cnt", 128'(scnt[1]), 128'(1));
`endif

    // Empty job: done straight away, no SRAM access.
    run(10'h055, 0, 0, -1, 0, 0, 1'b1);
`ifdef WEIGHT_FETCH_PERF_EN
    chk("stall_cnt_cleared", 128'({scnt[0], scnt[1]}), 128'(0));
`endif

    // Abort during tile 2 of 4, then a clean full job.
    run(10'h100, 4, 0, -1, 0, 12, 1'b1);
    run(10'h100, 4, 0, -1, 0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
